// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

  // Mode machine encoding; values are visible on the state output.
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } sw_state_e;

  // Quarter-second phase counter width (four quarters per second).
  localparam int PHASE_W = 2;

  // Adjust target selected by sw_sel.
  localparam logic SEL_SEC = 1'b0;
  localparam logic SEL_MIN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, optional stability filter and a
// one-cycle press pulse on the rising edge of the accepted level.
// Build option: STOPWATCH_CTRL_DEBOUNCE_EN enables the DB_CYCLES filter;
// without it the press pulse comes straight from the synchronized edge.
// A button held through reset produces no pulse until it has been seen
// released (r_armed) and pressed again.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  if (DB_CYCLES < 1) begin : g_cfg_err
    $error("btn_debounce: DB_CYCLES must be >= 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_db;
  logic r_armed;
  logic r_press;
  logic w_sync;

  assign w_sync = r_sync2;
  assign press  = r_press;

  // Synchronizer flops carry data only; left unreset so a held button stays
  // visible across reset and cannot be mistaken for a fresh press.
  always_ff @(posedge clk) begin
    r_sync1 <= btn;
    r_sync2 <= r_sync1;
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Accept a new level only after it has differed from the current one for
  // DB_CYCLES consecutive cycles; pulse on an accepted rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!w_sync) r_armed <= 1'b1;
      if (w_sync == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db    <= w_sync;
        r_cnt   <= '0;
        r_press <= w_sync & r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  // Track the synchronized level and pulse on its rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db    <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_db    <= w_sync;
      r_press <= w_sync & ~r_db & r_armed;
      if (!w_sync) r_armed <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns buttons/switches into counter
// enables, clear and adjust pulses, runs the PAUSED/RUN/ADJUST machine and
// owns the quarter-second prescaler and display blink masks.
// Build option: STOPWATCH_CTRL_DEBOUNCE_EN selects debounced buttons.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       tick_cnt,
  output logic       cnt_clr,
  output logic       adj_sec_inc,
  output logic       adj_min_inc,
  output logic       blink_sec,
  output logic       blink_min,
  output logic [1:0] state
);

  if ((CLK_HZ % 4 != 0) || (CLK_HZ < 8)) begin : g_cfg_err
    $error("stopwatch_ctrl: CLK_HZ must be a multiple of 4 and >= 8");
  end

  localparam int QDIV = CLK_HZ / 4;
  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

  sw_state_e          r_state;
  logic [QW-1:0]      r_q;
  logic [PHASE_W-1:0] r_phase;
  logic               r_sel;
  logic               r_adj_s1, r_adj_s2;
  logic               r_sel_s1, r_sel_s2;
  logic               r_tick, r_cnt_clr, r_adj_sec, r_adj_min;
  logic               w_pause_p, w_clr_p;
  logic               w_enter_adj, w_presc_en, w_qtr, w_fire;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_pause),
    .press (w_pause_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .press (w_clr_p)
  );

  // Level switches are only synchronized, never filtered.
  always_ff @(posedge clk) begin
    r_adj_s1 <= sw_adj;
    r_adj_s2 <= r_adj_s1;
    r_sel_s1 <= sw_sel;
    r_sel_s2 <= r_sel_s1;
  end

  assign w_enter_adj = r_adj_s2 && (r_state != ADJUST);
  assign w_presc_en  = (r_state == RUN) || (r_state == ADJUST);
  assign w_qtr       = w_presc_en && (r_q == QMAX);
  // A clear landing on a quarter boundary swallows that boundary's pulses.
  assign w_fire      = w_qtr && !w_clr_p;

  // Quarter prescaler and phase: hold while paused so the sub-second
  // fraction survives a pause; restart on clear and on entering ADJUST.
  // The blink target latches sw_sel only on quarter boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      r_phase <= '0;
      r_sel   <= SEL_SEC;
    end else begin
      if (w_clr_p || w_enter_adj) begin
        r_q     <= '0;
        r_phase <= '0;
      end else if (w_presc_en) begin
        if (r_q == QMAX) begin
          r_q     <= '0;
          r_phase <= r_phase + 1'b1;
        end else begin
          r_q <= r_q + 1'b1;
        end
      end
      if (w_enter_adj || w_qtr) r_sel <= r_sel_s2;
    end
  end

  // Mode machine with registered pulse outputs; sw_adj outranks a pause
  // press, and clear never changes the mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PAUSED;
      r_tick    <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_adj_sec <= 1'b0;
      r_adj_min <= 1'b0;
    end else begin
      r_cnt_clr <= w_clr_p;
      r_tick    <= w_fire && (r_state == RUN) && (r_phase == {PHASE_W{1'b1}});
      r_adj_sec <= w_fire && (r_state == ADJUST) && r_phase[0] && (r_sel_s2 == SEL_SEC);
      r_adj_min <= w_fire && (r_state == ADJUST) && r_phase[0] && (r_sel_s2 == SEL_MIN);
      if (r_adj_s2) begin
        r_state <= ADJUST;
      end else begin
        case (r_state)
          PAUSED:  if (w_pause_p) r_state <= RUN;
          RUN:     if (w_pause_p) r_state <= PAUSED;
          default: r_state <= PAUSED;
        endcase
      end
    end
  end

  assign tick_cnt    = r_tick;
  assign cnt_clr     = r_cnt_clr;
  assign adj_sec_inc = r_adj_sec;
  assign adj_min_inc = r_adj_min;
  assign blink_sec   = (r_state == ADJUST) && (r_sel == SEL_SEC) && r_phase[0];
  assign blink_min   = (r_state == ADJUST) && (r_sel == SEL_MIN) && r_phase[0];
  assign state       = r_state;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the MM:SS stopwatch counter. It turns raw board buttons and switches into the counter's single-cycle count enable, clear and adjust pulses, and runs the RUN / PAUSED / ADJUST mode machine. It also drives the display blink masks. It sits between the board I/O and the counter/display path, and owns all time-base prescaling.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; must be a multiple of 4, ≥ 8
- DB_CYCLES, 1_000_000, cycles a synchronized button must be stable before it is accepted
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; clock clk
- btn_pause  in  1  raw async button, toggles run/pause
- btn_clear  in  1  raw async button, clears the counter
- sw_adj  in  1  raw async level switch, 1 = adjust mode
- sw_sel  in  1  raw async level switch, adjust target: 0 = seconds, 1 = minutes
- tick_cnt  out  1  one-cycle 1 Hz count enable to the counter
- cnt_clr  out  1  one-cycle counter clear
- adj_sec_inc  out  1  one-cycle seconds increment, 2 Hz
- adj_min_inc  out  1  one-cycle minutes increment, 2 Hz
- blink_sec  out  1  1 = blank seconds digits
- blink_min  out  1  1 = blank minutes digits
- state  out  2  current mode: 0 PAUSED, 1 RUN, 2 ADJUST

## Operation
- All four inputs pass through 2-flop synchronizers. Buttons then pass through the debouncer.
- A press pulse is a 1-cycle pulse generated on the rising edge of the debounced level. Release produces nothing.
- Prescaler q counts 0..CLK_HZ/4-1. A quarter pulse fires when q wraps. A 2-bit phase counter advances on each quarter pulse.
- Prescaler behaviour by mode:
  - Runs in RUN and ADJUST.
  - Holds in PAUSED, so the sub-second fraction is preserved across a pause.
  - Zeroed by clear, and on entry to ADJUST.
- tick_cnt = quarter pulse AND phase==3 AND state==RUN.
- adj_sec_inc / adj_min_inc = quarter pulse AND phase[0]==1 AND state==ADJUST AND sw_sel==0 / 1.
- blink_sec = ADJUST AND sw_sel==0 AND phase[0]. blink_min = ADJUST AND sw_sel==1 AND phase[0].
- FSM:
  - Reset → PAUSED.
  - PAUSED + pause press → RUN.
  - RUN + pause press → PAUSED.
  - Any state + sw_adj==1 → ADJUST. This has priority over a pause press in the same cycle.
  - ADJUST + sw_adj==0 → PAUSED.
  - Pause press in ADJUST is ignored.
- Clear press in any state:
  - cnt_clr pulses; prescaler and phase are zeroed; state is unchanged.
  - Clear plus pause press in the same cycle: both are honored.

## Timing
- Reset values: all outputs 0, state=PAUSED, q=0, phase=0, debounced levels 0.
- Press latency: 2 sync cycles + DB_CYCLES stable cycles, then the press pulse. State/cnt_clr update on the next edge, so outputs are registered 1 cycle after the pulse.
- tick_cnt first asserts exactly CLK_HZ cycles after entering RUN from a zeroed prescaler. Thereafter the period is exactly CLK_HZ.
- Adjust pulse period: CLK_HZ/2.
- In the cycle where clear and a quarter pulse coincide, tick/adj pulses are suppressed.
- rst mid-press: the debouncer restarts, and no pulse is emitted for a button already held at reset release until it is released and pressed again.
- sw_sel change in ADJUST takes effect at the next quarter pulse. Phase is not reset.

## Configuration
- STOPWATCH_CTRL_DEBOUNCE_EN
  - Defined: buttons use the DB_CYCLES debouncer.
  - Undefined: debounce is bypassed and the press pulse is taken from the synchronized level edge; DB_CYCLES is unused.
  - Switches are never debounced.

## Structure
- Package stopwatch_pkg: state enum (PAUSED=0, RUN=1, ADJUST=2), phase width constant, sel encoding constants.
- Sub-module btn_debounce: synchronizer, stable counter, press-pulse output. Instantiated twice.

## Test plan
Bench parameters: CLK_HZ=16, DB_CYCLES=3.
- Reset, hold pause high 10 cycles → state=RUN after 2+3+1 cycles; tick_cnt pulses every 16 cycles; first pulse 16 cycles after entry.
- In RUN, press pause at cycle 7 of a second, wait 40 cycles, press again → state PAUSED then RUN; next tick_cnt 9 cycles after re-entering RUN.
- Pause pulse 2 cycles wide with debounce enabled → no state change. Same stimulus with macro undefined → toggles.
- sw_adj=1, sw_sel=1 → state=ADJUST; adj_min_inc every 8 cycles; blink_min toggles every 4 cycles; adj_sec_inc, tick_cnt stay 0. sw_adj=0 → state=PAUSED.
- Clear and pause pressed in the same cycle from PAUSED → cnt_clr one pulse; state=RUN; next tick_cnt exactly 16 cycles later.
- rst asserted while RUN mid-second with pause held → all outputs 0, state=PAUSED, no press pulse until pause is released and re-pressed.
